// File: rtl/chess_pkg.sv
// chess_pkg: definitions shared by the game control FSM and the move validator.
//   - piece codes and the player-1 offset
//   - piece_owner() / piece_kind() decode helpers
//   - validator FSM states and pawn move modes
//   - memory_manage encodings (who owns the board memory)
package chess_pkg;

   localparam logic [3:0] EMPTY          = 4'd0;
   localparam logic [3:0] PAWN           = 4'd1;
   localparam logic [3:0] ROOK           = 4'd2;
   localparam logic [3:0] KNIGHT         = 4'd3;
   localparam logic [3:0] BISHOP         = 4'd4;
   localparam logic [3:0] QUEEN          = 4'd5;
   localparam logic [3:0] KING           = 4'd6;
   localparam logic [3:0] PLAYER1_OFFSET = 4'd6;

   localparam logic [1:0] MM_CONTROL   = 2'b00;
   localparam logic [1:0] MM_VALIDATOR = 2'b01;
   localparam logic [1:0] MM_DATAPATH  = 2'b10;

   typedef enum logic [2:0] {
      K_NONE, K_PAWN, K_ROOK, K_KNIGHT, K_BISHOP, K_QUEEN, K_KING
   } kind_e;

   typedef enum logic [1:0] {PM_NONE, PM_FWD, PM_DIAG} pawn_mode_e;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_PATH_RD, S_PATH_CHK, S_DEST_RD, S_DEST_CHK, S_DONE
   } state_e;

   // Codes 7..15 belong to player 1; callers handle EMPTY separately.
   function automatic logic piece_owner(input logic [3:0] code);
      return code > KING;
   endfunction

   // Colour-independent piece type; unused codes 13..15 decode as no piece.
   function automatic kind_e piece_kind(input logic [3:0] code);
      logic [3:0] k;
      if (code == EMPTY || code > KING + PLAYER1_OFFSET) return K_NONE;
      k = (code > KING) ? code - PLAYER1_OFFSET : code;
      return kind_e'(k[2:0]);
   endfunction

endpackage

// File: rtl/move_validator_if.sv
// move_validator_if: bundle between game control (+ board memory) and the
// move validator.
//   master: control side; drives the request and the board read data.
//   slave : validator side; drives the board read address and the result.
interface move_validator_if;
   logic       enable;
   logic       current_player;
   logic [2:0] piece_x, piece_y;
   logic [2:0] move_x, move_y;
   logic [3:0] piece_to_move;
   logic [3:0] validate_square;
   logic [2:0] validate_x, validate_y;
   logic       validate_complete;
   logic       move_valid;
   logic       capture;

   modport master (
      output enable, current_player, piece_x, piece_y, move_x, move_y,
             piece_to_move, validate_square,
      input  validate_x, validate_y, validate_complete, move_valid, capture
   );

   modport slave (
      input  enable, current_player, piece_x, piece_y, move_x, move_y,
             piece_to_move, validate_square,
      output validate_x, validate_y, validate_complete, move_valid, capture
   );
endinterface

// File: rtl/move_geometry.sv
// move_geometry: purely combinational shape check of a move.
//   kind, player      : piece type and moving side
//   src_x/y, dst_x/y  : source and destination squares (x = row)
//   geom_ok           : move shape is legal for this piece
//   needs_path        : intermediate squares must be read and be empty
//   step_x/y          : unit step toward dest, 3-bit two's complement
//   pawn_mode         : FWD (dest must be empty) / DIAG (dest must be enemy)
module move_geometry
   import chess_pkg::*;
#(
   parameter logic [2:0] P0_PAWN_RANK = 3'd1,
   parameter logic [2:0] P1_PAWN_RANK = 3'd6
) (
   input  kind_e      kind,
   input  logic       player,
   input  logic [2:0] src_x,
   input  logic [2:0] src_y,
   input  logic [2:0] dst_x,
   input  logic [2:0] dst_y,
   output logic       geom_ok,
   output logic       needs_path,
   output logic [2:0] step_x,
   output logic [2:0] step_y,
   output pawn_mode_e pawn_mode
);
   logic signed [3:0] dx, dy;
   logic [2:0]        adx, ady, max_d;
   logic              fwd_one, fwd_two, on_start, straight, diagonal;

   // NOTE: every output is given a default before the case so that no path
   // through this block leaves a value unassigned and infers a latch.
   always_comb begin
      geom_ok    = 1'b0;
      needs_path = 1'b0;
      pawn_mode  = PM_NONE;

      dx    = $signed({1'b0, dst_x}) - $signed({1'b0, src_x});
      dy    = $signed({1'b0, dst_y}) - $signed({1'b0, src_y});
      adx   = dx[3] ? 3'(-dx) : 3'(dx);
      ady   = dy[3] ? 3'(-dy) : 3'(dy);
      max_d = (adx > ady) ? adx : ady;

      step_x = dx[3] ? 3'b111 : ((dx != 4'sd0) ? 3'b001 : 3'b000);
      step_y = dy[3] ? 3'b111 : ((dy != 4'sd0) ? 3'b001 : 3'b000);

      fwd_one  = player ? (dx == -4'sd1) : (dx == 4'sd1);
      fwd_two  = player ? (dx == -4'sd2) : (dx == 4'sd2);
      on_start = (src_x == (player ? P1_PAWN_RANK : P0_PAWN_RANK));
      straight = (adx == 3'd0) != (ady == 3'd0);
      diagonal = (adx == ady) && (adx != 3'd0);

      case (kind)
         K_KNIGHT: geom_ok = (adx == 3'd1 && ady == 3'd2) || (adx == 3'd2 && ady == 3'd1);
         K_KING:   geom_ok = (max_d == 3'd1);
         K_ROOK:   geom_ok = straight;
         K_BISHOP: geom_ok = diagonal;
         K_QUEEN:  geom_ok = straight || diagonal;
         K_PAWN: begin
            if (fwd_one && ady == 3'd0) begin
               geom_ok   = 1'b1;
               pawn_mode = PM_FWD;
            end else if (fwd_two && ady == 3'd0 && on_start) begin
               geom_ok   = 1'b1;
               pawn_mode = PM_FWD;
            end else if (fwd_one && ady == 3'd1) begin
               geom_ok   = 1'b1;
               pawn_mode = PM_DIAG;
            end
         end
         default: geom_ok = 1'b0;
      endcase

      // Knights jump and kings move one square, so only longer slides and the
      // pawn double step have squares in between.
      if (geom_ok && kind != K_KNIGHT && max_d > 3'd1) needs_path = 1'b1;
   end
endmodule

// File: rtl/move_validator.sv
// move_validator: decides whether the selected piece may legally move from
// (piece_x,piece_y) to (move_x,move_y), walking the board memory to check
// blocking pieces and the destination square.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : move_validator_if.slave (request, board read port, result)
module move_validator
   import chess_pkg::*;
#(
   parameter logic [2:0] P0_PAWN_RANK = 3'd1,
   parameter logic [2:0] P1_PAWN_RANK = 3'd6
) (
   input  logic             clk,
   input  logic             reset,
   move_validator_if.slave  bus
);
   state_e     state, state_n;

   logic       player_q;
   logic [3:0] piece_q;
   logic [2:0] src_x_q, src_y_q, dst_x_q, dst_y_q;
   logic [2:0] step_x_q, step_y_q, cur_x_q, cur_y_q;
   pawn_mode_e pawn_mode_q;
   logic       valid_q, capture_q;
   logic       complete_r, move_valid_r, capture_r;

   kind_e      kind;
   logic       geom_ok, needs_path, check_ok;
   logic [2:0] step_x, step_y, nxt_x, nxt_y;
   pawn_mode_e pawn_mode;

   assign kind = piece_kind(piece_q);

   move_geometry #(
      .P0_PAWN_RANK(P0_PAWN_RANK),
      .P1_PAWN_RANK(P1_PAWN_RANK)
   ) u_geom (
      .kind(kind), .player(player_q),
      .src_x(src_x_q), .src_y(src_y_q), .dst_x(dst_x_q), .dst_y(dst_y_q),
      .geom_ok(geom_ok), .needs_path(needs_path),
      .step_x(step_x), .step_y(step_y), .pawn_mode(pawn_mode)
   );

   assign check_ok = (kind != K_NONE) && (piece_owner(piece_q) == player_q) &&
                     !(src_x_q == dst_x_q && src_y_q == dst_y_q) && geom_ok;
   assign nxt_x = cur_x_q + step_x_q;
   assign nxt_y = cur_y_q + step_y_q;

   always_comb begin
      state_n        = state;
      bus.validate_x = 3'd0;
      bus.validate_y = 3'd0;
      case (state)
         S_IDLE:     if (bus.enable) state_n = S_CHECK;
         S_CHECK:    state_n = !check_ok ? S_DONE : (needs_path ? S_PATH_RD : S_DEST_RD);
         S_PATH_RD: begin
            bus.validate_x = cur_x_q;
            bus.validate_y = cur_y_q;
            state_n        = S_PATH_CHK;
         end
         S_PATH_CHK: begin
            if (bus.validate_square != EMPTY)            state_n = S_DONE;
            else if (nxt_x == dst_x_q && nxt_y == dst_y_q) state_n = S_DEST_RD;
            else                                         state_n = S_PATH_RD;
         end
         S_DEST_RD: begin
            bus.validate_x = dst_x_q;
            bus.validate_y = dst_y_q;
            state_n        = S_DEST_CHK;
         end
         S_DEST_CHK: state_n = S_DONE;
         S_DONE:     state_n = S_DONE;
         default:    state_n = S_IDLE;
      endcase
      // Losing the memory grant abandons the evaluation from any state.
      if (state != S_IDLE && !bus.enable) state_n = S_IDLE;
   end

   // NOTE: registers are updated with non-blocking assignments so every
   // always_ff reads the pre-edge value of the others, as the hardware does.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         player_q    <= 1'b0;
         piece_q     <= 4'd0;
         src_x_q     <= 3'd0;
         src_y_q     <= 3'd0;
         dst_x_q     <= 3'd0;
         dst_y_q     <= 3'd0;
         step_x_q    <= 3'd0;
         step_y_q    <= 3'd0;
         cur_x_q     <= 3'd0;
         cur_y_q     <= 3'd0;
         pawn_mode_q <= PM_NONE;
         valid_q     <= 1'b0;
         capture_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (bus.enable) begin
               player_q  <= bus.current_player;
               piece_q   <= bus.piece_to_move;
               src_x_q   <= bus.piece_x;
               src_y_q   <= bus.piece_y;
               dst_x_q   <= bus.move_x;
               dst_y_q   <= bus.move_y;
               valid_q   <= 1'b0;
               capture_q <= 1'b0;
            end
            S_CHECK: begin
               step_x_q    <= step_x;
               step_y_q    <= step_y;
               cur_x_q     <= src_x_q + step_x;
               cur_y_q     <= src_y_q + step_y;
               pawn_mode_q <= pawn_mode;
            end
            S_PATH_CHK: begin
               cur_x_q <= nxt_x;
               cur_y_q <= nxt_y;
            end
            S_DEST_CHK: begin
               if (bus.validate_square == EMPTY) begin
                  valid_q <= (pawn_mode_q != PM_DIAG);
               end else if (piece_owner(bus.validate_square) == player_q) begin
                  valid_q <= 1'b0;
               end else begin
                  capture_q <= 1'b1;
                  valid_q   <= (pawn_mode_q != PM_FWD);
               end
            end
            default: ;
         endcase
      end
   end

   // Result outputs are registered one edge behind S_DONE and drop on the
   // same edge that returns the FSM to S_IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         complete_r   <= 1'b0;
         move_valid_r <= 1'b0;
         capture_r    <= 1'b0;
      end else begin
         complete_r   <= (state == S_DONE) && bus.enable;
         move_valid_r <= (state == S_DONE) && bus.enable && valid_q;
         capture_r    <= (state == S_DONE) && bus.enable && capture_q;
      end
   end

   assign bus.validate_complete = complete_r;
   assign bus.move_valid        = move_valid_r;
   assign bus.capture           = capture_r;
endmodule

// File: tb/tb_move_validator.sv
// tb_move_validator: directed self-checking bench for move_validator.
// A small registered board memory answers validate_x/y one cycle later.
module tb_move_validator;
   import chess_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   logic [3:0] board [8][8];
   logic seen_05;

   always #5 clk = ~clk;

   move_validator_if bus ();

   move_validator #(.P0_PAWN_RANK(3'd1), .P1_PAWN_RANK(3'd6)) dut (
      .clk(clk), .reset(rst_n), .bus(bus)
   );

   always @(posedge clk) bus.validate_square <= board[bus.validate_x][bus.validate_y];
   always @(negedge clk) if (bus.validate_x == 3'd0 && bus.validate_y == 3'd5) seen_05 = 1'b1;

   task automatic clear_board();
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) board[i][j] = 4'd0;
      seen_05 = 1'b0;
   endtask

   task automatic start_move(input logic pl, input logic [2:0] px, py, mx, my, input logic [3:0] pc);
      @(negedge clk);
      bus.current_player = pl;
      bus.piece_x = px; bus.piece_y = py;
      bus.move_x = mx;  bus.move_y = my;
      bus.piece_to_move = pc;
      bus.enable = 1'b1;
   endtask

   // Runs one request and returns edges from the sampling edge to complete
   // (-1 if it never completes). With scramble set, inputs change after latch.
   task automatic do_move(input logic pl, input logic [2:0] px, py, mx, my,
                          input logic [3:0] pc, input logic scramble, output int lat);
      start_move(pl, px, py, mx, my, pc);
      lat = -1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (n == 0 && scramble) begin
            bus.piece_to_move = 4'd0; bus.move_x = 3'd7; bus.move_y = 3'd7;
            bus.current_player = ~pl;
         end
         if (bus.validate_complete) begin lat = n; break; end
      end
   endtask

   task automatic release_enable();
      @(negedge clk); bus.enable = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.enable = 1'b0; bus.current_player = 1'b0; bus.piece_to_move = 4'd0;
      bus.piece_x = 3'd0; bus.piece_y = 3'd0; bus.move_x = 3'd0; bus.move_y = 3'd0;
      clear_board();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.validate_complete, bus.move_valid, bus.capture} !== 3'b000) begin
         failures++; $display("FAIL reset_outputs got=%b want=000", {bus.validate_complete, bus.move_valid, bus.capture});
      end
      checks++;
      if ({bus.validate_x, bus.validate_y} !== 6'd0) begin
         failures++; $display("FAIL reset_addr got=%0d,%0d want=0,0", bus.validate_x, bus.validate_y);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_knight();
      int lat;
      clear_board();
      do_move(1'b0, 3'd0, 3'd1, 3'd2, 3'd2, 4'd3, 1'b0, lat);
      checks++; if (lat !== 4) begin failures++; $display("FAIL knight_latency got=%0d want=4", lat); end
      checks++; if ({bus.move_valid, bus.capture} !== 2'b10) begin
         failures++; $display("FAIL knight_result got=%b want=10", {bus.move_valid, bus.capture}); end
      @(posedge clk); #1;
      checks++; if ({bus.validate_complete, bus.move_valid} !== 2'b11) begin
         failures++; $display("FAIL knight_hold got=%b want=11", {bus.validate_complete, bus.move_valid}); end
      release_enable();
      checks++; if ({bus.validate_complete, bus.move_valid, bus.capture} !== 3'b000) begin
         failures++; $display("FAIL knight_release got=%b want=000", {bus.validate_complete, bus.move_valid, bus.capture}); end
   endtask

   task automatic test_slider_path();
      int lat;
      clear_board();
      board[0][3] = 4'd7;
      do_move(1'b0, 3'd0, 3'd0, 3'd0, 3'd5, 4'd2, 1'b0, lat);
      checks++; if (lat !== 8) begin failures++; $display("FAIL rook_block_latency got=%0d want=8", lat); end
      checks++; if (bus.move_valid !== 1'b0) begin failures++; $display("FAIL rook_block_valid got=%b want=0", bus.move_valid); end
      checks++; if (seen_05 !== 1'b0) begin failures++; $display("FAIL rook_block_dest_read got=%b want=0", seen_05); end
      release_enable();
      clear_board();
      do_move(1'b0, 3'd0, 3'd0, 3'd0, 3'd5, 4'd2, 1'b0, lat);
      checks++; if (lat !== 12) begin failures++; $display("FAIL rook_clear_latency got=%0d want=12", lat); end
      checks++; if ({bus.move_valid, seen_05} !== 2'b11) begin
         failures++; $display("FAIL rook_clear_result got=%b want=11", {bus.move_valid, seen_05}); end
      release_enable();
      board[4][0] = 4'd9;
      do_move(1'b1, 3'd7, 3'd3, 3'd4, 3'd0, 4'd11, 1'b0, lat);
      checks++; if (lat !== 8) begin failures++; $display("FAIL queen_latency got=%0d want=8", lat); end
      checks++; if ({bus.move_valid, bus.capture} !== 2'b00) begin
         failures++; $display("FAIL queen_own_dest got=%b want=00", {bus.move_valid, bus.capture}); end
      release_enable();
      clear_board();
      board[5][5] = 4'd8;
      do_move(1'b0, 3'd2, 3'd2, 3'd5, 3'd5, 4'd4, 1'b0, lat);
      checks++; if ({lat == 8, bus.move_valid, bus.capture} !== 3'b111) begin
         failures++; $display("FAIL bishop_capture got=lat%0d %b want=lat8 11", lat, {bus.move_valid, bus.capture}); end
      release_enable();
   endtask

   task automatic test_pawn();
      int lat;
      clear_board();
      do_move(1'b0, 3'd1, 3'd4, 3'd3, 3'd4, 4'd1, 1'b0, lat);
      checks++; if ({lat == 6, bus.move_valid} !== 2'b11) begin
         failures++; $display("FAIL pawn_double got=lat%0d valid=%b want=lat6 valid=1", lat, bus.move_valid); end
      release_enable();
      do_move(1'b0, 3'd2, 3'd4, 3'd4, 3'd4, 4'd1, 1'b0, lat);
      checks++; if ({lat == 2, bus.move_valid} !== 2'b10) begin
         failures++; $display("FAIL pawn_double_off_rank got=lat%0d valid=%b want=lat2 valid=0", lat, bus.move_valid); end
      release_enable();
      board[2][5] = 4'd8;
      do_move(1'b0, 3'd1, 3'd4, 3'd2, 3'd5, 4'd1, 1'b0, lat);
      checks++; if ({lat == 4, bus.move_valid, bus.capture} !== 3'b111) begin
         failures++; $display("FAIL pawn_diag_capture got=lat%0d %b want=lat4 11", lat, {bus.move_valid, bus.capture}); end
      release_enable();
      board[2][4] = 4'd8;
      do_move(1'b0, 3'd1, 3'd4, 3'd2, 3'd4, 4'd1, 1'b0, lat);
      checks++; if ({bus.move_valid, bus.capture} !== 2'b01) begin
         failures++; $display("FAIL pawn_fwd_blocked got=%b want=01", {bus.move_valid, bus.capture}); end
      release_enable();
      do_move(1'b0, 3'd1, 3'd4, 3'd2, 3'd3, 4'd1, 1'b0, lat);
      checks++; if ({lat == 4, bus.move_valid} !== 2'b10) begin
         failures++; $display("FAIL pawn_diag_empty got=lat%0d valid=%b want=lat4 valid=0", lat, bus.move_valid); end
      release_enable();
      do_move(1'b1, 3'd6, 3'd2, 3'd5, 3'd2, 4'd7, 1'b0, lat);
      checks++; if ({lat == 4, bus.move_valid} !== 2'b11) begin
         failures++; $display("FAIL pawn_p1_fwd got=lat%0d valid=%b want=lat4 valid=1", lat, bus.move_valid); end
      release_enable();
   endtask

   task automatic test_ownership();
      int lat;
      clear_board();
      do_move(1'b0, 3'd2, 3'd2, 3'd3, 3'd3, 4'd8, 1'b0, lat);
      checks++; if ({lat == 2, bus.move_valid} !== 2'b10) begin
         failures++; $display("FAIL enemy_piece got=lat%0d valid=%b want=lat2 valid=0", lat, bus.move_valid); end
      release_enable();
      do_move(1'b0, 3'd3, 3'd3, 3'd3, 3'd3, 4'd5, 1'b0, lat);
      checks++; if ({lat == 2, bus.move_valid} !== 2'b10) begin
         failures++; $display("FAIL null_move got=lat%0d valid=%b want=lat2 valid=0", lat, bus.move_valid); end
      release_enable();
      do_move(1'b0, 3'd3, 3'd3, 3'd4, 3'd4, 4'd0, 1'b0, lat);
      checks++; if ({lat == 2, bus.move_valid} !== 2'b10) begin
         failures++; $display("FAIL empty_piece got=lat%0d valid=%b want=lat2 valid=0", lat, bus.move_valid); end
      release_enable();
   endtask

   task automatic test_abort();
      int lat;
      clear_board();
      start_move(1'b0, 3'd0, 3'd0, 3'd0, 3'd5, 4'd2);
      repeat (4) @(posedge clk);
      #1;
      checks++; if (bus.validate_y !== 3'd2) begin failures++; $display("FAIL abort_pre_addr got=%0d want=2", bus.validate_y); end
      @(negedge clk); bus.enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({bus.validate_complete, bus.move_valid, bus.validate_x, bus.validate_y} !== 8'd0) begin
         failures++; $display("FAIL abort_idle got=%b,%b,%0d,%0d want=0,0,0,0", bus.validate_complete, bus.move_valid, bus.validate_x, bus.validate_y); end
      do_move(1'b0, 3'd0, 3'd1, 3'd2, 3'd2, 4'd3, 1'b0, lat);
      checks++; if ({lat == 4, bus.move_valid} !== 2'b11) begin
         failures++; $display("FAIL abort_restart got=lat%0d valid=%b want=lat4 valid=1", lat, bus.move_valid); end
      release_enable();
      start_move(1'b0, 3'd0, 3'd0, 3'd0, 3'd5, 4'd2);
      repeat (4) @(posedge clk);
      @(negedge clk); rst_n = 1'b0; bus.enable = 1'b0;
      #1;
      checks++; if ({bus.validate_complete, bus.move_valid, bus.validate_y} !== 5'd0) begin
         failures++; $display("FAIL reset_midpath got=%b,%b,%0d want=0,0,0", bus.validate_complete, bus.move_valid, bus.validate_y); end
      @(negedge clk); rst_n = 1'b1;
      do_move(1'b1, 3'd5, 3'd5, 3'd3, 3'd4, 4'd9, 1'b0, lat);
      checks++; if ({lat == 4, bus.move_valid} !== 2'b11) begin
         failures++; $display("FAIL reset_restart got=lat%0d valid=%b want=lat4 valid=1", lat, bus.move_valid); end
      release_enable();
   endtask

   task automatic test_back_to_back();
      int lat;
      clear_board();
      board[4][4] = 4'd3;
      do_move(1'b1, 3'd5, 3'd5, 3'd4, 3'd4, 4'd12, 1'b1, lat);
      checks++; if ({lat == 4, bus.move_valid, bus.capture} !== 3'b111) begin
         failures++; $display("FAIL king_capture_scrambled got=lat%0d %b want=lat4 11", lat, {bus.move_valid, bus.capture}); end
      release_enable();
      do_move(1'b1, 3'd5, 3'd5, 3'd3, 3'd5, 4'd12, 1'b0, lat);
      checks++; if ({lat == 2, bus.move_valid, bus.capture} !== 3'b100) begin
         failures++; $display("FAIL king_two_step got=lat%0d %b want=lat2 00", lat, {bus.move_valid, bus.capture}); end
      release_enable();
   endtask

   initial begin
      test_reset();
      test_knight();
      test_slider_path();
      test_pawn();
      test_ownership();
      test_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/move_validator.md
Name: move_validator

Overview:
- Judges whether the selected piece may legally move from (piece_x,piece_y) to (move_x,move_y) on the 8x8 board.
- Sits directly downstream of the game control FSM, replacing its mocked validator.
- Runs while control grants it board-memory access (memory_manage==2'b01, presented here as `enable`). It reads the board through validate_x/validate_y and validate_square.
- Returns validate_complete and move_valid to control.

Parameters:
P0_PAWN_RANK, 1, x row where player-0 pawns start (double step allowed from here)
P1_PAWN_RANK, 6, x row where player-1 pawns start

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  level; high while control grants memory to the validator
current_player  input  1  0 = player 0 (pieces 1-6), 1 = player 1 (pieces 7-12)
piece_x, piece_y  input  3 each  source square
move_x, move_y  input  3 each  destination square
piece_to_move  input  4  piece code: 0 empty; 1 pawn, 2 rook, 3 knight, 4 bishop, 5 queen, 6 king; +6 for player 1
validate_square  input  4  board contents at validate_x/validate_y, valid one cycle after address
validate_x, validate_y  output  3 each  board read address
validate_complete  output  1  result ready; held until enable drops
move_valid  output  1  legality result; meaningful only while validate_complete=1
capture  output  1  destination held an enemy piece; meaningful with validate_complete

Behaviour:
- Reset (reset=0, async): state S_IDLE; all outputs 0; latched registers 0.
- Coordinates: x is the row (pawn direction); dx = move_x - piece_x, dy = move_y - piece_y, both signed 4-bit. No wrap-around.
- S_IDLE
  - On an enable=1 edge, latch all inputs and go to S_CHECK.
  - Outputs are 0 in this state.
- S_CHECK: geometry and ownership checks, in priority order.
  - piece_to_move==0, piece not owned by current_player, or dx=dy=0 -> S_DONE, valid=0.
  - Knight: legal iff {|dx|,|dy|} = {1,2}.
  - King: legal iff max(|dx|,|dy|)=1.
  - Rook: legal iff dx=0 xor dy=0.
  - Bishop: legal iff |dx|=|dy|.
  - Queen: rook or bishop geometry.
  - Pawn (forward f = +1 for player 0, -1 for player 1):
    - dx=f, dy=0: dest must be empty.
    - dx=2f, dy=0, source row = start rank: intermediate and dest must be empty.
    - dx=f, |dy|=1: dest must hold an enemy piece.
    - Any other pawn move is illegal.
  - No castling, en passant, promotion, or check detection.
  - Geometry fail -> S_DONE, valid=0.
  - Sliders (rook/bishop/queen) and the pawn double step with distance >1: step = sign(dx),sign(dy), cursor = source+step, go to S_PATH_RD. Otherwise go to S_DEST_RD.
- S_PATH_RD: drive validate_x/y = cursor.
- S_PATH_CHK: sample validate_square.
  - Nonzero -> S_DONE, valid=0.
  - Else cursor += step. If the new cursor equals dest -> S_DEST_RD, else S_PATH_RD.
- S_DEST_RD: drive validate_x/y = dest.
- S_DEST_CHK: sample validate_square.
  - Own-colour piece -> invalid.
  - Enemy piece -> capture=1; valid unless pawn straight move.
  - Empty -> valid unless pawn diagonal.
  - Go to S_DONE.
- S_DONE
  - validate_complete=1; move_valid and capture registered and stable.
  - Stay while enable=1. enable=0 -> S_IDLE, outputs cleared next edge.
- Latency from the edge that samples enable=1 to validate_complete high:
  - Geometry/ownership fail: 2 cycles.
  - Direct move: 4 cycles.
  - Path of k intermediate squares: 4+2k cycles (max k=6 -> 16).
- enable dropping in any state other than S_IDLE aborts to S_IDLE on the next edge; no result is produced.
- Inputs changing after the latch are ignored until the next S_IDLE.
- validate_x/y = 0 outside the read states.

Decomposition:
- Shared package chess_pkg:
  - Piece codes (EMPTY, PAWN..KING, PLAYER1_OFFSET).
  - Functions piece_owner() and piece_kind().
  - Validator state localparams.
  - memory_manage encodings (MM_CONTROL=00, MM_VALIDATOR=01, MM_DATAPATH=10).
- Combinational sub-module move_geometry:
  - Inputs: kind, player, source, dest.
  - Outputs: geom_ok, needs_path, step_x/step_y, pawn_mode (NONE/FWD/DIAG).

Test Plan:
- Player 0 knight 3 from (0,1) to (2,2), dest empty -> complete 4 cycles after enable, move_valid=1, capture=0.
- Player 0 rook 2 at (0,0) to (0,5), square (0,3) holds 7 -> S_PATH_CHK fails at (0,3), move_valid=0; dest (0,5) is never addressed.
- Player 0 pawn at (1,4): to (3,4) with (2,4),(3,4) empty -> valid; same from (2,4) to (4,4) -> invalid in 2 cycles; to (2,5) with 8 there -> valid, capture=1.
- Player 1 queen 11 from (7,3) to (4,0), path empty, dest holds 9 (own) -> move_valid=0 at 4+2*2=8 cycles.
- piece_to_move=8 with current_player=0, or dest==source -> move_valid=0, complete at cycle 2.
- Deassert enable mid-path, and separately pulse reset low mid-path -> state S_IDLE, all outputs 0; a fresh enable restarts cleanly.
